lcd_pattern_gen: RTL and testbench

Upstream pixel source for lcd_drive. It replaces the static colorbar generator with a selectable, frame-synchronous test-pattern engine.
- Consumes pixel_xpos/pixel_ypos and h_disp/v_disp from lcd_drive.
- Returns pixel_data with a fixed 2-cycle latency. lcd_drive's position lead is set to 2 to match.
- Runs on lcd_pclk, the clock produced by clk_div. Supports all panel sizes reported via lcd_id.

---
 rtl/lcd_pkg.sv | 59 +++++
 rtl/lcd_pattern_gen_if.sv | 27 ++
 rtl/lcd_bar_thresh.sv | 66 ++++++
 rtl/lcd_pattern_gen.sv | 115 +++++++++++
 tb/tb_lcd_pattern_gen.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD test-pattern engine:
// pattern modes, threshold FSM states, widths and the colour-bar palette.
package lcd_pkg;

  localparam int RGB_W = 24;
  localparam int POS_W = 11;

  typedef enum logic [2:0] {
    MODE_VBAR   = 3'd0,
    MODE_HBAR   = 3'd1,
    MODE_CHECK  = 3'd2,
    MODE_GRAY   = 3'd3,
    MODE_SCROLL = 3'd4,
    MODE_SOLID  = 3'd5,
    MODE_RSVD   = 3'd6,
    MODE_OFF    = 3'd7
  } mode_t;

  typedef enum logic {
    CALC_IDLE = 1'b0,
    CALC_RUN  = 1'b1
  } calc_state_t;

  localparam logic [RGB_W-1:0] PAL_WHITE   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] PAL_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] PAL_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] PAL_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] PAL_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] PAL_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] PAL_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] PAL_BLACK   = 24'h000000;

  function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
    logic [RGB_W-1:0] c;
    case (idx)
      3'd0:    c = PAL_WHITE;
      3'd1:    c = PAL_YELLOW;
      3'd2:    c = PAL_CYAN;
      3'd3:    c = PAL_GREEN;
      3'd4:    c = PAL_MAGENTA;
      3'd5:    c = PAL_RED;
      3'd6:    c = PAL_BLUE;
      default: c = PAL_BLACK;
    endcase
    return c;
  endfunction

  // Bar index = how many of the seven thresholds lie at or below pos.
  function automatic logic [2:0] bar_index(input logic [7:1][POS_W-1:0] thr,
                                           input logic [POS_W:0] pos);
    logic [2:0] n;
    n = '0;
    for (int i = 1; i < 8; i++) begin
      if ({1'b0, thr[i]} <= pos) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// Pixel-stream bundle between lcd_drive (master) and the pattern generator (slave).
interface lcd_pattern_gen_if;
  import lcd_pkg::*;

  // No valid/ready: the master presents a position every lcd_pclk cycle and
  // pixel_data for that position appears exactly two cycles later.
  logic              frame_sync;
  logic [2:0]        mode_sel;
  logic [POS_W-1:0]  pixel_xpos;
  logic [POS_W-1:0]  pixel_ypos;
  logic [POS_W-1:0]  h_disp;
  logic [POS_W-1:0]  v_disp;
  logic [RGB_W-1:0]  pixel_data;
  logic [15:0]       frame_cnt;
  logic              calc_busy;
  calc_state_t       calc_state;

  modport master (
    output frame_sync, mode_sel, pixel_xpos, pixel_ypos, h_disp, v_disp,
    input  pixel_data, frame_cnt, calc_busy, calc_state
  );

  modport slave (
    input  frame_sync, mode_sel, pixel_xpos, pixel_ypos, h_disp, v_disp,
    output pixel_data, frame_cnt, calc_busy, calc_state
  );
endinterface

// File: rtl/lcd_bar_thresh.sv
// Dual-lane bar threshold accumulator: after each start it builds
// thr[k] = k*step for k=1..7 in x and y, one step per cycle.
module lcd_bar_thresh
  import lcd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [POS_W-1:0]      step_x,
  input  logic [POS_W-1:0]      step_y,
  output logic [7:1][POS_W-1:0] thr_x,
  output logic [7:1][POS_W-1:0] thr_y,
  output logic                  busy,
  output calc_state_t           state
);

  calc_state_t          state_nxt;
  logic [2:0]           k, k_nxt;
  logic [POS_W-1:0]     bw_q, bh_q;
  logic [7:0][POS_W-1:0] acc_x, acc_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CALC_IDLE;
      k     <= 3'd1;
      bw_q  <= '0;
      bh_q  <= '0;
      acc_x <= '0;
      acc_y <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (start) begin
        bw_q <= step_x;
        bh_q <= step_y;
      end
      // acc[0] stays zero so step 1 needs no special case.
      if (state == CALC_RUN) begin
        acc_x[k] <= acc_x[k - 3'd1] + bw_q;
        acc_y[k] <= acc_y[k - 3'd1] + bh_q;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    if (start) begin
      state_nxt = CALC_RUN;
      k_nxt     = 3'd1;
    end else begin
      case (state)
        CALC_RUN: begin
          if (k == 3'd7) state_nxt = CALC_IDLE;
          else           k_nxt     = k + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state == CALC_RUN);
  assign thr_x = acc_x[7:1];
  assign thr_y = acc_y[7:1];

endmodule

// File: rtl/lcd_pattern_gen.sv
// Frame-synchronous test-pattern generator feeding lcd_drive; returns
// pixel_data two lcd_pclk cycles after the position is presented.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int               SCROLL_STEP = 4,
  parameter logic [RGB_W-1:0] SOLID_RGB   = 24'h0000FF,
  parameter int               CHK_BIT     = 5
) (
  input  logic            lcd_pclk,
  input  logic            rst,
  lcd_pattern_gen_if.slave bus
);

  logic                  fs_q;
  logic                  fb;
  mode_t                 mode_q;
  logic [POS_W-1:0]      scroll;
  logic [POS_W:0]        scroll_sum, scroll_nxt;
  logic [15:0]           frame_cnt;
  logic [7:1][POS_W-1:0] thr_x, thr_y;
  logic                  calc_busy;
  calc_state_t           calc_state;

  logic [POS_W:0]        ex_sum, ex;
  logic [2:0]            s1_bx, s1_by;
  logic                  s1_oor, s1_chk;
  logic [7:0]            s1_gray;
  mode_t                 s1_mode;
  logic [RGB_W-1:0]      pix_nxt, pixel_data;

  // fs_q is the registered copy, so fb is high for exactly one cycle per rise.
  assign fb = bus.frame_sync & ~fs_q;

  assign scroll_sum = {1'b0, scroll} + (POS_W+1)'(SCROLL_STEP);
  assign scroll_nxt = (scroll_sum >= {1'b0, bus.h_disp}) ?
                      scroll_sum - {1'b0, bus.h_disp} : scroll_sum;

  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      fs_q      <= 1'b0;
      mode_q    <= MODE_VBAR;
      scroll    <= '0;
      frame_cnt <= '0;
    end else begin
      fs_q <= bus.frame_sync;
      if (fb) begin
        mode_q    <= mode_t'(bus.mode_sel);
        frame_cnt <= frame_cnt + 16'd1;
        scroll    <= scroll_nxt[POS_W-1:0];
      end
    end
  end

  lcd_bar_thresh u_thresh (
    .clk    (lcd_pclk),
    .rst    (rst),
    .start  (fb),
    .step_x ({3'b000, bus.h_disp[POS_W-1:3]}),
    .step_y ({3'b000, bus.v_disp[POS_W-1:3]}),
    .thr_x  (thr_x),
    .thr_y  (thr_y),
    .busy   (calc_busy),
    .state  (calc_state)
  );

  // Scroll offset wraps around the active width with a single subtraction.
  assign ex_sum = {1'b0, bus.pixel_xpos} +
                  ((mode_q == MODE_SCROLL) ? {1'b0, scroll} : '0);
  assign ex     = (ex_sum >= {1'b0, bus.h_disp}) ? ex_sum - {1'b0, bus.h_disp} : ex_sum;

  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      s1_bx   <= '0;
      s1_by   <= '0;
      s1_oor  <= 1'b0;
      s1_chk  <= 1'b0;
      s1_gray <= '0;
      s1_mode <= MODE_VBAR;
    end else begin
      s1_bx   <= bar_index(thr_x, ex);
      s1_by   <= bar_index(thr_y, {1'b0, bus.pixel_ypos});
      s1_oor  <= (bus.pixel_xpos >= bus.h_disp) || (bus.pixel_ypos >= bus.v_disp);
      s1_chk  <= bus.pixel_xpos[CHK_BIT] ^ bus.pixel_ypos[CHK_BIT];
      s1_gray <= bus.pixel_xpos[9:2];
      s1_mode <= mode_q;
    end
  end

  always_comb begin
    pix_nxt = PAL_BLACK;
    if (!s1_oor) begin
      case (s1_mode)
        MODE_VBAR:   pix_nxt = bar_color(s1_bx);
        MODE_HBAR:   pix_nxt = bar_color(s1_by);
        MODE_CHECK:  pix_nxt = s1_chk ? PAL_WHITE : PAL_BLACK;
        MODE_GRAY:   pix_nxt = {3{s1_gray}};
        MODE_SCROLL: pix_nxt = bar_color(s1_bx);
        MODE_SOLID:  pix_nxt = SOLID_RGB;
        default:     pix_nxt = PAL_BLACK;
      endcase
    end
  end

  always_ff @(posedge lcd_pclk) begin
    if (rst) pixel_data <= '0;
    else     pixel_data <= pix_nxt;
  end

  assign bus.pixel_data = pixel_data;
  assign bus.frame_cnt  = frame_cnt;
  assign bus.calc_busy  = calc_busy;
  assign bus.calc_state = calc_state;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Bench for lcd_pattern_gen: a reference model predicts each pixel when its
// position is driven; the monitor pops and compares two cycles later.
module tb_lcd_pattern_gen;
  import lcd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  lcd_pattern_gen_if bus();

  lcd_pattern_gen #(.SCROLL_STEP(4), .SOLID_RGB(24'h0000FF), .CHK_BIT(5)) dut (
    .lcd_pclk (clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q[$];
  logic        in_vld = 1'b0;
  logic [1:0]  vld_d  = 2'b00;

  // model state
  int m_mode = 0, m_scroll = 0, m_bw = 0, m_bh = 0;
  logic [15:0] m_cnt = 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] model_pix(input int x, input int y);
    logic [23:0] pal[8];
    logic [7:0]  g;
    int hd, vd, ex, bx, by;
    pal = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    hd = int'(bus.h_disp);
    vd = int'(bus.v_disp);
    if (x >= hd || y >= vd) return 24'h0;
    ex = x + ((m_mode == 4) ? m_scroll : 0);
    if (ex >= hd) ex = ex - hd;
    bx = 0;
    by = 0;
    for (int k = 1; k < 8; k++) begin
      if (k * m_bw <= ex) bx++;
      if (k * m_bh <= y)  by++;
    end
    g = 8'(x >> 2);
    case (m_mode)
      0, 4:    return pal[bx];
      1:       return pal[by];
      2:       return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      3:       return {g, g, g};
      5:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_frame(input int m);
    m_mode   = m;
    m_cnt    = m_cnt + 16'd1;
    m_scroll = m_scroll + 4;
    if (m_scroll >= int'(bus.h_disp)) m_scroll = m_scroll - int'(bus.h_disp);
    m_bw = int'(bus.h_disp) >> 3;
    m_bh = int'(bus.v_disp) >> 3;
  endtask

  task automatic model_reset();
    m_mode = 0; m_scroll = 0; m_bw = 0; m_bh = 0; m_cnt = 16'd0;
  endtask

  // Rise frame_sync, hold it for `hold` cycles, and measure the CALC window.
  task automatic do_frame(input int m, input int hold);
    int busy;
    busy = 0;
    @(negedge clk);
    bus.mode_sel   = 3'(m);
    bus.frame_sync = 1'b1;
    model_frame(m);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == hold - 1) bus.frame_sync = 1'b0;
      if (bus.calc_busy) busy++;
    end
    check("busy_len", 32'(busy), 32'd7);
    check("frame_cnt", {16'h0, bus.frame_cnt}, {16'h0, m_cnt});
  endtask

  task automatic send(input int x, input int y);
    @(negedge clk);
    bus.pixel_xpos = 11'(x);
    bus.pixel_ypos = 11'(y);
    in_vld = 1'b1;
    exp_q.push_back(model_pix(x, y));
  endtask

  task automatic drain();
    @(negedge clk);
    in_vld = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_pix", {8'h0, bus.pixel_data}, 32'h0);
    check("rst_cnt", {16'h0, bus.frame_cnt}, 32'h0);
    check("rst_busy", {31'h0, bus.calc_busy}, 32'h0);
    rst = 1'b0;
    model_reset();
  endtask

  always @(posedge clk) vld_d <= {vld_d[0], in_vld & ~rst};

  always @(negedge clk) begin
    if (vld_d[1]) begin
      if (exp_q.size() == 0) check("q_underflow", 32'd1, 32'd0);
      else check("pix", {8'h0, bus.pixel_data}, {8'h0, exp_q.pop_front()});
    end
  end

  initial begin
    int busy;
    bus.frame_sync = 1'b0;
    bus.mode_sel   = 3'd0;
    bus.pixel_xpos = '0;
    bus.pixel_ypos = '0;
    bus.h_disp     = 11'd800;
    bus.v_disp     = 11'd480;
    repeat (3) @(negedge clk);
    check("rst_pix", {8'h0, bus.pixel_data}, 32'h0);
    check("rst_cnt", {16'h0, bus.frame_cnt}, 32'h0);
    check("rst_busy", {31'h0, bus.calc_busy}, 32'h0);
    rst = 1'b0;

    // first frame: zero thresholds give black bars
    send(0, 0); send(400, 10); drain();

    do_frame(0, 1);
    send(0, 0); send(150, 0); send(799, 0);
    for (int i = 0; i < 8; i++) send($urandom_range(0, 820), $urandom_range(0, 490));
    drain();

    do_frame(1, 1);
    send(0, 130); send(5, 479); send(5, 300); drain();
    do_frame(2, 1);
    send(32, 0); send(32, 32); send(0, 0); send(100, 70); drain();
    do_frame(3, 1);
    send(400, 0); send(799, 1); drain();
    do_frame(5, 1);
    send(10, 10); send(900, 10); drain();
    do_frame(6, 1); send(10, 10); drain();
    do_frame(7, 1); send(10, 10); drain();

    // mode_sel change mid-frame is deferred to the next boundary
    do_frame(0, 1);
    bus.mode_sel = 3'd1;
    send(0, 130); send(150, 0); drain();
    do_frame(1, 1);
    send(0, 130); drain();

    // frame_sync held high yields a single boundary
    do_frame(0, 5);

    // second boundary during CALC restarts the full 7-step run
    @(negedge clk);
    bus.frame_sync = 1'b1; bus.mode_sel = 3'd0; model_frame(0);
    @(negedge clk); bus.frame_sync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_mid", {31'h0, bus.calc_busy}, 32'h1);
    bus.frame_sync = 1'b1; model_frame(0);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) bus.frame_sync = 1'b0;
      if (bus.calc_busy) busy++;
    end
    check("busy_restart", 32'(busy), 32'd7);
    send(699, 0); send(700, 0); send(600, 0); drain();

    // reset mid-CALC with a non-black pixel in the pipe
    bus.pixel_xpos = 11'd0; bus.pixel_ypos = 11'd0;
    @(negedge clk); bus.frame_sync = 1'b1; model_frame(0);
    @(negedge clk); bus.frame_sync = 1'b0;
    pulse_reset();
    send(0, 0); send(900, 10); send(10, 500); drain();

    // scrolling bars: 3 boundaries -> offset 12, then 197 more wrap to 0
    for (int i = 0; i < 3; i++) do_frame(4, 1);
    send(90, 5); send(0, 0); send(795, 0); drain();
    for (int i = 0; i < 197; i++) do_frame(4, 1);
    send(90, 5); send(799, 0); drain();

    // smaller panel, all modes with random positions
    pulse_reset();
    bus.h_disp = 11'd480; bus.v_disp = 11'd272;
    for (int m = 0; m < 8; m++) begin
      do_frame(m, 1);
      for (int i = 0; i < 6; i++) send($urandom_range(0, 500), $urandom_range(0, 290));
      drain();
    end

    // h_disp < 8: all x thresholds zero, bars are black
    pulse_reset();
    bus.h_disp = 11'd6; bus.v_disp = 11'd480;
    do_frame(0, 1);
    send(3, 3); send(0, 100); drain();
    do_frame(1, 1);
    send(3, 130); drain();

    check("leftover", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
